// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - state, opcode, function and datapath select encodings for the multi-cycle sequencer
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_LUI  = 3'b100;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

  localparam logic [1:0] A3_RD    = 2'b00;
  localparam logic [1:0] A3_RT    = 2'b01;
  localparam logic [1:0] A3_RA    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_DM    = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;

  // One-hot instruction class; exactly one field is set for any word.
  typedef struct packed {
    logic is_add;
    logic is_sub;
    logic is_xor;
    logic is_jr;
    logic is_ori;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_lui;
    logic is_jal;
    logic is_nop;
    logic is_illegal;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - instruction word to one-hot instruction class, with illegal flag
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] ins,
  output logic [11:0] cls
);

  iclass_t c;
  logic [5:0] op;
  logic [5:0] fn;

  assign op  = ins[31:26];
  assign fn  = ins[5:0];
  assign cls = c;

  // Only the all-zero word is nop; any other unlisted opcode or func is illegal.
  always_comb begin
    c = '0;
    if (ins == 32'd0) begin
      c.is_nop = 1'b1;
    end else begin
      case (op)
        OP_RTYPE: begin
          case (fn)
            FN_ADD:  c.is_add     = 1'b1;
            FN_SUB:  c.is_sub     = 1'b1;
            FN_XOR:  c.is_xor     = 1'b1;
            FN_JR:   c.is_jr      = 1'b1;
            default: c.is_illegal = 1'b1;
          endcase
        end
        OP_ORI:  c.is_ori     = 1'b1;
        OP_LW:   c.is_lw      = 1'b1;
        OP_SW:   c.is_sw      = 1'b1;
        OP_BEQ:  c.is_beq     = 1'b1;
        OP_LUI:  c.is_lui     = 1'b1;
        OP_JAL:  c.is_jal     = 1'b1;
        default: c.is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control sequencer; MC_ILLEGAL_TRAP_EN selects trap-on-illegal
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int FETCH_WAIT = 0,
  parameter int MEM_WAIT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic        zero,
  output logic        pc_we,
  output logic        ir_we,
  output logic [1:0]  npc_sel,
  output logic        grf_we,
  output logic [1:0]  a3_sel,
  output logic [1:0]  grf_wd_sel,
  output logic        alu_b_sel,
  output logic        imm_sext,
  output logic [2:0]  alu_op,
  output logic        dm_we,
  output logic        instr_done,
  output logic [2:0]  state_o
);

  localparam logic [3:0] FETCH_LAST = 4'(FETCH_WAIT);
  localparam logic [3:0] MEM_LAST   = 4'(MEM_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  iclass_t    cls;
  logic       fetch_last;
  logic       mem_last;
  logic       retire_nop;
  logic       to_wb;

  mc_decode u_decode (
    .ins (ins),
    .cls (cls)
  );

  assign fetch_last = (wait_cnt == FETCH_LAST);
  assign mem_last   = (wait_cnt == MEM_LAST);
  assign to_wb      = cls.is_add | cls.is_sub | cls.is_xor | cls.is_ori | cls.is_lui;
  assign state_o    = state;

`ifdef MC_ILLEGAL_TRAP_EN
  assign retire_nop = cls.is_nop;
`else
  assign retire_nop = cls.is_nop | cls.is_illegal;
`endif

  // Phase sequencing; the wait counter only runs in FETCH and MEM and is cleared on leaving them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (fetch_last) begin
            wait_cnt <= 4'd0;
            state    <= ST_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_DECODE: begin
          if (retire_nop)      state <= ST_FETCH;
          else if (cls.is_jal) state <= ST_WB;
          else                 state <= ST_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
          if (cls.is_illegal)  state <= ST_TRAP;
`endif
        end
        ST_EXEC: begin
          if (cls.is_lw | cls.is_sw) state <= ST_MEM;
          else if (to_wb)            state <= ST_WB;
          else                       state <= ST_FETCH;
        end
        ST_MEM: begin
          if (mem_last) begin
            wait_cnt <= 4'd0;
            state    <= cls.is_lw ? ST_WB : ST_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_WB:   state <= ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
        ST_TRAP: state <= ST_TRAP;
`endif
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Control outputs from state and decoded IR; reset forces every output to 0 so an aborted instruction writes nothing.
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    npc_sel    = NPC_PC4;
    grf_we     = 1'b0;
    a3_sel     = A3_RD;
    grf_wd_sel = WD_ALU;
    alu_b_sel  = 1'b0;
    imm_sext   = 1'b0;
    alu_op     = ALU_ADD;
    dm_we      = 1'b0;
    instr_done = 1'b0;
    if (!reset) begin
      // ALU setup is held from EXEC until the instruction retires so MEM and WB see a stable result.
      if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
        if (cls.is_add)                alu_op = ALU_ADD;
        if (cls.is_sub | cls.is_beq)   alu_op = ALU_SUB;
        if (cls.is_xor)                alu_op = ALU_XOR;
        if (cls.is_ori) begin
          alu_op    = ALU_OR;
          alu_b_sel = 1'b1;
        end
        if (cls.is_lui) begin
          alu_op    = ALU_LUI;
          alu_b_sel = 1'b1;
        end
        if (cls.is_lw | cls.is_sw) begin
          alu_op    = ALU_ADD;
          alu_b_sel = 1'b1;
          imm_sext  = 1'b1;
        end
      end
      case (state)
        ST_FETCH:  ir_we = fetch_last;
        ST_DECODE: begin
          if (retire_nop) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
          end
        end
        ST_EXEC: begin
          if (cls.is_beq) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            npc_sel    = zero ? NPC_BR : NPC_PC4;
          end else if (cls.is_jr) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            npc_sel    = NPC_RS;
          end
        end
        ST_MEM: begin
          if (cls.is_sw && mem_last) begin
            dm_we      = 1'b1;
            pc_we      = 1'b1;
            instr_done = 1'b1;
          end
        end
        ST_WB: begin
          grf_we     = 1'b1;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          if (cls.is_jal) begin
            a3_sel     = A3_RA;
            grf_wd_sel = WD_PC4;
            npc_sel    = NPC_JAL;
          end else if (cls.is_lw) begin
            a3_sel     = A3_RT;
            grf_wd_sel = WD_DM;
          end else if (cls.is_ori | cls.is_lui) begin
            a3_sel     = A3_RT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl against a cycle-trace model
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic       ir_we;
    logic [1:0] npc;
    logic       grf_we;
    logic [1:0] a3;
    logic [1:0] wd;
    logic       bsel;
    logic       sext;
    logic [2:0] alu;
    logic       dm_we;
    logic       done;
  } obs_t;

  localparam int NI = 4;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst      [NI];
  logic [31:0] ins      [NI];
  logic        zero     [NI];
  logic        pc_we_w  [NI];
  logic        ir_we_w  [NI];
  logic [1:0]  npc_w    [NI];
  logic        grf_we_w [NI];
  logic [1:0]  a3_w     [NI];
  logic [1:0]  wd_w     [NI];
  logic        bsel_w   [NI];
  logic        sext_w   [NI];
  logic [2:0]  alu_w    [NI];
  logic        dm_we_w  [NI];
  logic        done_w   [NI];
  logic [2:0]  st_w     [NI];
  obs_t        obs      [NI];

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];
  obs_t got_q[$];

  always #5 clk = ~clk;

  function automatic int fw_of(input int k);
    return (k == 3) ? 2 : 0;
  endfunction

  function automatic int mw_of(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : (k == 3) ? 3 : 0;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    multicycle_ctrl #(
      .FETCH_WAIT((g == 3) ? 2 : 0),
      .MEM_WAIT  ((g == 1) ? 2 : (g == 2) ? 1 : (g == 3) ? 3 : 0)
    ) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .ins        (ins[g]),
      .zero       (zero[g]),
      .pc_we      (pc_we_w[g]),
      .ir_we      (ir_we_w[g]),
      .npc_sel    (npc_w[g]),
      .grf_we     (grf_we_w[g]),
      .a3_sel     (a3_w[g]),
      .grf_wd_sel (wd_w[g]),
      .alu_b_sel  (bsel_w[g]),
      .imm_sext   (sext_w[g]),
      .alu_op     (alu_w[g]),
      .dm_we      (dm_we_w[g]),
      .instr_done (done_w[g]),
      .state_o    (st_w[g])
    );
    assign obs[g] = {st_w[g], pc_we_w[g], ir_we_w[g], npc_w[g], grf_we_w[g], a3_w[g],
                     wd_w[g], bsel_w[g], sext_w[g], alu_w[g], dm_we_w[g], done_w[g]};
  end

  function automatic string classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (w == 32'd0) return "nop";
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   return "add";
          6'h22:   return "sub";
          6'h26:   return "xor";
          6'h08:   return "jr";
          default: return "ill";
        endcase
      end
      6'h0d:   return "ori";
      6'h23:   return "lw";
      6'h2b:   return "sw";
      6'h04:   return "beq";
      6'h0f:   return "lui";
      6'h03:   return "jal";
      default: return "ill";
    endcase
  endfunction

  // Expected per-cycle observation list for one instruction, built from the phase/cycle rules.
  function automatic void build_exp(input logic [31:0] w, input logic z, input int fw, input int mw);
    string      nm;
    obs_t       o;
    logic [2:0] alu;
    logic       b;
    logic       s;
    exp_q.delete();
    nm  = classify(w);
    alu = 3'd0;
    b   = 1'b0;
    s   = 1'b0;
    if (nm == "sub" || nm == "beq") alu = 3'd1;
    if (nm == "xor") alu = 3'd2;
    if (nm == "ori") begin alu = 3'd3; b = 1'b1; end
    if (nm == "lui") begin alu = 3'd4; b = 1'b1; end
    if (nm == "lw" || nm == "sw") begin b = 1'b1; s = 1'b1; end
    for (int i = 0; i <= fw; i++) begin
      o = '0;
      o.ir_we = (i == fw);
      exp_q.push_back(o);
    end
    o = '0;
    o.st = 3'd1;
    if (nm == "nop" || (nm == "ill" && !TRAP)) begin
      o.pc_we = 1'b1;
      o.done  = 1'b1;
      exp_q.push_back(o);
      return;
    end
    exp_q.push_back(o);
    if (nm == "ill") begin
      for (int i = 0; i < 4; i++) begin
        o = '0;
        o.st = 3'd5;
        exp_q.push_back(o);
      end
      return;
    end
    if (nm != "jal") begin
      o = '0;
      o.st = 3'd2; o.alu = alu; o.bsel = b; o.sext = s;
      if (nm == "beq") begin o.pc_we = 1'b1; o.done = 1'b1; o.npc = z ? 2'd1 : 2'd0; end
      if (nm == "jr")  begin o.pc_we = 1'b1; o.done = 1'b1; o.npc = 2'd3; end
      exp_q.push_back(o);
      if (nm == "beq" || nm == "jr") return;
      if (nm == "lw" || nm == "sw") begin
        for (int i = 0; i <= mw; i++) begin
          o = '0;
          o.st = 3'd3; o.alu = alu; o.bsel = b; o.sext = s;
          if (nm == "sw" && i == mw) begin o.dm_we = 1'b1; o.pc_we = 1'b1; o.done = 1'b1; end
          exp_q.push_back(o);
        end
        if (nm == "sw") return;
      end
    end
    o = '0;
    o.st = 3'd4; o.grf_we = 1'b1; o.pc_we = 1'b1; o.done = 1'b1;
    o.alu = alu; o.bsel = b; o.sext = s;
    if (nm == "jal")                     begin o.a3 = 2'd2; o.wd = 2'd2; o.npc = 2'd2; end
    else if (nm == "lw")                 begin o.a3 = 2'd1; o.wd = 2'd1; end
    else if (nm == "ori" || nm == "lui") begin o.a3 = 2'd1; end
    exp_q.push_back(o);
  endfunction

  function automatic logic [31:0] rand_word(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0:       return {6'h00, r[25:6], 6'h20};
      1:       return {6'h00, r[25:6], 6'h22};
      2:       return {6'h00, r[25:6], 6'h26};
      3:       return {6'h00, r[25:6], 6'h08};
      4:       return {6'h0d, r[25:0]};
      5:       return {6'h23, r[25:0]};
      6:       return {6'h2b, r[25:0]};
      7:       return {6'h04, r[25:0]};
      8:       return {6'h0f, r[25:0]};
      9:       return {6'h03, r[25:0]};
      10:      return 32'd0;
      11:      return {6'h3f, r[25:0]};
      default: return {6'h00, r[25:6], 6'h21};
    endcase
  endfunction

  task automatic apply_reset(input int k);
    @(posedge clk); #1;
    rst[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_instr(input int k, input logic [31:0] w, input logic z);
    build_exp(w, z, fw_of(k), mw_of(k));
    @(posedge clk); #1;
    rst[k]  = 1'b0;
    ins[k]  = w;
    zero[k] = z;
    got_q.delete();
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      got_q.push_back(obs[k]);
    end
  endtask

  task automatic test_reset();
    obs_t zero_o;
    zero_o = '0;
    for (int k = 0; k < NI; k++) begin
      ins[k]  = 32'h00853020;
      zero[k] = 1'b1;
      apply_reset(k);
      checks++;
      if (obs[k] !== zero_o) begin
        errors++;
        $display("FAIL reset k=%0d got=%h exp=%h", k, obs[k], zero_o);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] w;
    apply_reset(0);
    for (int n = 0; n < 9; n++) begin
      w = (n == 0) ? 32'h00853020 : rand_word((n % 5 == 3) ? 4 : (n % 5 == 4) ? 8 : n % 5);
      run_instr(0, w, 1'($urandom));
      for (int c = 0; c < exp_q.size(); c++) begin
        checks++;
        if (got_q[c] !== exp_q[c]) begin
          errors++;
          $display("FAIL alu_ops w=%h cyc=%0d got=%h exp=%h", w, c, got_q[c], exp_q[c]);
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    int first_done;
    int dm_cnt;
    int dm_at;
    apply_reset(1);
    run_instr(1, 32'h8C880004, 1'b0);
    first_done = -1;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (first_done < 0 && got_q[c].done) first_done = c;
      checks++;
      if (got_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL lw_wait cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
    checks++;
    if (first_done !== 6) begin
      errors++;
      $display("FAIL lw_len done_at=%0d exp=6", first_done);
    end
    apply_reset(2);
    run_instr(2, 32'hAC880004, 1'b1);
    dm_cnt = 0;
    dm_at  = -1;
    for (int c = 0; c < exp_q.size(); c++) begin
      if (got_q[c].dm_we) begin dm_cnt++; dm_at = c; end
      checks++;
      if (got_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL sw_wait cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
    checks++;
    if (dm_cnt !== 1 || dm_at !== 4 || !got_q[4].pc_we) begin
      errors++;
      $display("FAIL sw_dm_we count=%0d at=%0d pc_we=%b exp count=1 at=4 pc_we=1", dm_cnt, dm_at, got_q[4].pc_we);
    end
  endtask

  task automatic test_branch_jump();
    logic [31:0] seq [4];
    logic        zs  [4];
    seq[0] = 32'h10850003; zs[0] = 1'b1;
    seq[1] = 32'h10850003; zs[1] = 1'b0;
    seq[2] = 32'h0C000010; zs[2] = 1'b0;
    seq[3] = 32'h03E00008; zs[3] = 1'b1;
    apply_reset(0);
    for (int n = 0; n < 4; n++) begin
      run_instr(0, seq[n], zs[n]);
      for (int c = 0; c < exp_q.size(); c++) begin
        checks++;
        if (got_q[c] !== exp_q[c]) begin
          errors++;
          $display("FAIL branch_jump w=%h z=%b cyc=%0d got=%h exp=%h", seq[n], zs[n], c, got_q[c], exp_q[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    apply_reset(1);
    build_exp(32'h8C880004, 1'b0, fw_of(1), mw_of(1));
    @(posedge clk); #1;
    rst[1] = 1'b0;
    ins[1] = 32'h8C880004;
    for (int c = 0; c < 4; c++) @(negedge clk);
    checks++;
    if (obs[1] !== exp_q[3]) begin
      errors++;
      $display("FAIL reset_mid_pre got=%h exp=%h", obs[1], exp_q[3]);
    end
    rst[1] = 1'b1;
    #1;
    o = '0;
    o.st = 3'd3;
    checks++;
    if (obs[1] !== o) begin
      errors++;
      $display("FAIL reset_mid_hold got=%h exp=%h", obs[1], o);
    end
    @(negedge clk);
    o = '0;
    checks++;
    if (obs[1] !== o) begin
      errors++;
      $display("FAIL reset_mid_after got=%h exp=%h", obs[1], o);
    end
    run_instr(1, 32'h00853020, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (got_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL reset_mid_restart cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_illegal();
    apply_reset(0);
    run_instr(0, 32'hFC000000, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (got_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
    if (TRAP) apply_reset(0);
    run_instr(0, 32'd0, 1'b0);
    for (int c = 0; c < exp_q.size(); c++) begin
      checks++;
      if (got_q[c] !== exp_q[c]) begin
        errors++;
        $display("FAIL after_illegal cyc=%0d got=%h exp=%h", c, got_q[c], exp_q[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    logic        z;
    for (int k = 0; k < NI; k++) begin
      apply_reset(k);
      for (int n = 0; n < 25; n++) begin
        w = rand_word($urandom_range(0, TRAP ? 10 : 12));
        z = 1'($urandom);
        run_instr(k, w, z);
        for (int c = 0; c < exp_q.size(); c++) begin
          checks++;
          if (got_q[c] !== exp_q[c]) begin
            errors++;
            $display("FAIL back_to_back k=%0d w=%h z=%b cyc=%0d got=%h exp=%h", k, w, z, c, got_q[c], exp_q[c]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k]  = 1'b1;
      ins[k]  = 32'd0;
      zero[k] = 1'b0;
    end
    test_reset();
    test_alu_ops();
    test_mem_wait();
    test_branch_jump();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
